alu_cmd_sequencer: RTL and testbench

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

---
 rtl/alu_cmd_sequencer_pkg.sv | 32 +++
 rtl/alu_cmd_sequencer_if.sv | 28 ++
 rtl/alu_rsp_fifo.sv | 49 ++++
 rtl/alu_cmd_sequencer.sv | 109 ++++++++++
 tb/tb_alu_cmd_sequencer.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared types, widths and helpers for the ALU command sequencer.
// Widths, the FSM state type, the FIFO entry layout and the overflow check.
package alu_cmd_sequencer_pkg;

  localparam int unsigned ALU_SEL_W    = 3;
  localparam int unsigned ALU_OPND_W   = 4;
  localparam int unsigned ALU_RES_W    = 6;
  localparam int unsigned RSP_W        = ALU_SEL_W + ALU_RES_W + 1;
  localparam int unsigned SETTLE_CNT_W = 4;
  localparam int unsigned OP_COUNT_W   = 8;

  // Range a result must fit to be representable in 5 signed bits.
  localparam int OVF_MIN = -16;
  localparam int OVF_MAX = 15;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  typedef struct packed {
    logic [ALU_SEL_W-1:0]        sel;
    logic signed [ALU_RES_W-1:0] res;
    logic                        ovf;
  } rsp_t;

  function automatic logic res_ovf(input logic signed [ALU_RES_W-1:0] r);
    return (int'(r) < OVF_MIN) || (int'(r) > OVF_MAX);
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command and response channels of the ALU command sequencer.
// The master modport is the environment side; the slave modport is the sequencer.
interface alu_cmd_sequencer_if;
  import alu_cmd_sequencer_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ALU_SEL_W-1:0]  cmd_sel;
  logic [ALU_OPND_W-1:0] cmd_a;
  logic [ALU_OPND_W-1:0] cmd_b;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ALU_RES_W-1:0]  rsp_res;
  logic [ALU_SEL_W-1:0]  rsp_sel;
  logic                  rsp_ovf;

  modport master (
    output cmd_valid, cmd_sel, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_res, rsp_sel, rsp_ovf
  );

  modport slave (
    input  cmd_valid, cmd_sel, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_res, rsp_sel, rsp_ovf
  );

endinterface

// File: rtl/alu_rsp_fifo.sv
// Small response FIFO; the head is read straight from storage so that
// valid and head depend only on registered state.
module alu_rsp_fifo #(
  parameter  int unsigned DEPTH = 2,
  parameter  int unsigned WIDTH = 10,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && (count < CNT_W'(DEPTH));
  assign pop_ok  = pop && (count != '0);
  assign head    = mem[rd_ptr];
  assign valid   = (count != '0);

  // Pointers wrap at DEPTH, which need not be a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issues one command at a time to an external arithmetic unit, waits for it to
// settle, and queues the result with its select and an overflow flag.
module alu_cmd_sequencer
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned RSP_DEPTH     = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  alu_cmd_sequencer_if.slave           bus,
  output logic [ALU_SEL_W-1:0]         alu_sel,
  output logic [ALU_OPND_W-1:0]        alu_a,
  output logic [ALU_OPND_W-1:0]        alu_b,
  input  logic signed [ALU_RES_W-1:0]  alu_res,
  output logic [OP_COUNT_W-1:0]        op_count
);

  localparam int unsigned OCC_W = $clog2(RSP_DEPTH + 1);

  state_t                  state;
  state_t                  state_next;
  logic [SETTLE_CNT_W-1:0] settle_cnt;
  logic [SETTLE_CNT_W-1:0] cnt_next;
  logic                    ready;
  logic                    accept;
  logic                    push;
  logic [OCC_W-1:0]        occ;
  rsp_t                    push_rsp;
  rsp_t                    head_rsp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Ready only when idle with a free FIFO slot, so a capture never meets a full FIFO.
  always_comb begin
    state_next = state;
    cnt_next   = settle_cnt;
    ready      = 1'b0;
    accept     = 1'b0;
    push       = 1'b0;
    unique case (state)
      IDLE: begin
        ready = (occ < OCC_W'(RSP_DEPTH));
        if (bus.cmd_valid && ready) begin
          accept     = 1'b1;
          cnt_next   = SETTLE_CNT_W'(SETTLE_CYCLES);
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        cnt_next = settle_cnt - SETTLE_CNT_W'(1);
        if (settle_cnt == SETTLE_CNT_W'(1)) state_next = CAPTURE;
      end
      CAPTURE: begin
        push       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
      alu_sel    <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      op_count   <= '0;
    end else begin
      settle_cnt <= cnt_next;
      if (accept) begin
        alu_sel <= bus.cmd_sel;
        alu_a   <= bus.cmd_a;
        alu_b   <= bus.cmd_b;
      end
      if (push) op_count <= op_count + OP_COUNT_W'(1);
    end
  end

  always_comb begin
    push_rsp     = '0;
    push_rsp.sel = alu_sel;
    push_rsp.res = alu_res;
    push_rsp.ovf = res_ovf(alu_res);
  end

  alu_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (RSP_W)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_rsp),
    .pop       (bus.rsp_ready),
    .head      (head_rsp),
    .valid     (bus.rsp_valid),
    .count     (occ)
  );

  assign bus.cmd_ready = ready;
  assign bus.rsp_res   = head_rsp.res;
  assign bus.rsp_sel   = head_rsp.sel;
  assign bus.rsp_ovf   = head_rsp.ovf;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a small behavioural arithmetic unit.
module tb_alu_cmd_sequencer;
  import alu_cmd_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_cmd_sequencer_if bus_if ();

  logic [ALU_SEL_W-1:0]        alu_sel;
  logic [ALU_OPND_W-1:0]       alu_a;
  logic [ALU_OPND_W-1:0]       alu_b;
  logic signed [ALU_RES_W-1:0] alu_res;
  logic [OP_COUNT_W-1:0]       op_count;

  int n_checks = 0;
  int n_fail   = 0;
  int vcount;

  alu_cmd_sequencer #(
    .SETTLE_CYCLES (1),
    .RSP_DEPTH     (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus_if.slave),
    .alu_sel  (alu_sel),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_res  (alu_res),
    .op_count (op_count)
  );

  // Arithmetic unit: 0 pass a, 1 a-1, 2 a-b, 3 -a, 4 a&b, 5 a|b, 6 a+b, 7 a<<<2.
  logic signed [ALU_RES_W-1:0] sa;
  logic signed [ALU_RES_W-1:0] sb;
  assign sa = {{2{alu_a[3]}}, alu_a};
  assign sb = {{2{alu_b[3]}}, alu_b};
  always_comb begin
    alu_res = '0;
    case (alu_sel)
      3'd0: alu_res = sa;
      3'd1: alu_res = sa - 6'sd1;
      3'd2: alu_res = sa - sb;
      3'd3: alu_res = -sa;
      3'd4: alu_res = sa & sb;
      3'd5: alu_res = sa | sb;
      3'd6: alu_res = sa + sb;
      default: alu_res = sa <<< 2;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_sel   = s;
    bus_if.cmd_a     = a;
    bus_if.cmd_b     = b;
    tick();
    bus_if.cmd_valid = 1'b0;
  endtask

  task automatic pop();
    bus_if.rsp_ready = 1'b1;
    tick();
    bus_if.rsp_ready = 1'b0;
  endtask

  initial begin
    rst_n            = 1'b0;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_sel   = '0;
    bus_if.cmd_a     = '0;
    bus_if.cmd_b     = '0;
    bus_if.rsp_ready = 1'b0;

    #12;
    check("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    check("rst_op_count",  32'(op_count),         32'd0);
    check("rst_alu_sel",   32'(alu_sel),          32'd0);
    check("rst_alu_a",     32'(alu_a),            32'd0);
    check("rst_rsp_res",   32'(bus_if.rsp_res),   32'd0);
    check("rst_rsp_ovf",   32'(bus_if.rsp_ovf),   32'd0);
    #1 rst_n = 1'b1;
    tick();
    check("post_rst_ready", 32'(bus_if.cmd_ready), 32'd1);

    // 3 + 4 through select 6, result pushed two edges after accept
    issue(3'd6, 4'd3, 4'd4);
    check("a_alu_sel",  32'(alu_sel),          32'd6);
    check("a_alu_a",    32'(alu_a),            32'd3);
    check("a_alu_b",    32'(alu_b),            32'd4);
    check("a_busy",     32'(bus_if.cmd_ready), 32'd0);
    tick();
    check("a_no_rsp_e1", 32'(bus_if.rsp_valid), 32'd0);
    tick();
    check("a_rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
    check("a_rsp_res",   32'(bus_if.rsp_res),   32'h07);
    check("a_rsp_sel",   32'(bus_if.rsp_sel),   32'd6);
    check("a_rsp_ovf",   32'(bus_if.rsp_ovf),   32'd0);
    check("a_op_count",  32'(op_count),         32'd1);
    check("a_ready",     32'(bus_if.cmd_ready), 32'd1);
    pop();
    check("a_popped", 32'(bus_if.rsp_valid), 32'd0);

    // -8 <<< 2 = -32 overflows; -8 - 1 = -9 does not
    issue(3'd7, 4'h8, 4'h0);
    tick(); tick();
    check("b1_rsp_res", 32'(bus_if.rsp_res), 32'h20);
    check("b1_rsp_ovf", 32'(bus_if.rsp_ovf), 32'd1);
    check("b1_rsp_sel", 32'(bus_if.rsp_sel), 32'd7);
    pop();
    issue(3'd1, 4'h8, 4'h0);
    tick(); tick();
    check("b2_rsp_res", 32'(bus_if.rsp_res), 32'h37);
    check("b2_rsp_ovf", 32'(bus_if.rsp_ovf), 32'd0);
    check("b2_op_count", 32'(op_count),      32'd3);
    pop();

    // Fill the FIFO with the consumer stalled; offered commands are ignored
    issue(3'd2, 4'd5, 4'd2);
    tick(); tick();
    issue(3'd5, 4'd3, 4'd4);
    tick(); tick();
    check("c_full_ready", 32'(bus_if.cmd_ready), 32'd0);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_sel   = 3'd3;
    bus_if.cmd_a     = 4'd2;
    bus_if.cmd_b     = 4'd0;
    tick(); tick();
    check("c_ignored_sel", 32'(alu_sel),  32'd5);
    check("c_op_count",    32'(op_count), 32'd5);
    bus_if.cmd_valid = 1'b0;
    check("c_head0_res", 32'(bus_if.rsp_res), 32'h03);
    check("c_head0_sel", 32'(bus_if.rsp_sel), 32'd2);
    pop();
    check("c_ready_after_pop", 32'(bus_if.cmd_ready), 32'd1);
    check("c_head1_res", 32'(bus_if.rsp_res), 32'h07);
    check("c_head1_sel", 32'(bus_if.rsp_sel), 32'd5);
    pop();
    check("c_empty", 32'(bus_if.rsp_valid), 32'd0);

    // Back-to-back with an always-ready consumer: one op per three cycles
    bus_if.rsp_ready = 1'b1;
    bus_if.cmd_sel   = 3'd0;
    bus_if.cmd_a     = 4'd1;
    bus_if.cmd_b     = 4'd0;
    bus_if.cmd_valid = 1'b1;
    vcount = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (bus_if.rsp_valid) vcount++;
    end
    bus_if.cmd_valid = 1'b0;
    check("d_valid_cycles", 32'(vcount),         32'd3);
    check("d_op_count",     32'(op_count),       32'd8);
    check("d_rsp_res",      32'(bus_if.rsp_res), 32'h01);
    tick();
    check("d_drained", 32'(bus_if.rsp_valid), 32'd0);
    bus_if.rsp_ready = 1'b0;

    // Reset pulse while settling discards the operation
    issue(3'd6, 4'd1, 4'd1);
    #2 rst_n = 1'b0;
    #1;
    check("e_rst_alu_sel",  32'(alu_sel),  32'd0);
    check("e_rst_op_count", 32'(op_count), 32'd0);
    #2 rst_n = 1'b1;
    tick(); tick(); tick();
    check("e_no_rsp",   32'(bus_if.rsp_valid), 32'd0);
    check("e_op_count", 32'(op_count),         32'd0);
    check("e_ready",    32'(bus_if.cmd_ready), 32'd1);

    // 257 operations wrap op_count back to 1
    bus_if.rsp_ready = 1'b1;
    bus_if.cmd_sel   = 3'd6;
    bus_if.cmd_a     = 4'd1;
    bus_if.cmd_b     = 4'd1;
    bus_if.cmd_valid = 1'b1;
    repeat (768) tick();
    check("f_wrap_256", 32'(op_count), 32'd0);
    repeat (3) tick();
    bus_if.cmd_valid = 1'b0;
    check("f_wrap_257", 32'(op_count),         32'd1);
    check("f_rsp_res",  32'(bus_if.rsp_res),   32'h02);
    check("f_rsp_vld",  32'(bus_if.rsp_valid), 32'd1);
    bus_if.rsp_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
